// File: rtl/acc_wr_buf.sv
// Write buffer between the conv engine result stream and the AXI write master.
// Groups result words into bursts of up to BURST_LEN, one burst outstanding at a time.
module acc_wr_buf #(
  parameter int DATA_WIDTH = 512,
  parameter int WORD_BYTE  = DATA_WIDTH / 8,
  parameter int DEPTH      = 64,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_WIDTH = 64,
  localparam int LW = $clog2(BURST_LEN) + 1,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  end_conv,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wreq_valid,
  input  logic                  wreq_ready,
  output logic [ADDR_WIDTH-1:0] wreq_addr,
  output logic [LW-1:0]         wreq_len,
  output logic                  wdata_valid,
  input  logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_last,
  input  logic                  wmst_done,
  output logic                  write_buffer_wait,
  output logic [CW-1:0]         fill_count
);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [LW-1:0]         len_q, len_d, beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  flush_q, flush_d;
  logic                  push, pop, last_beat;

  assign in_ready          = (cnt_q != CW'(DEPTH));
  assign push              = in_valid && in_ready;
  assign pop               = wdata_valid && wdata_ready;
  assign wdata             = mem_q[rd_ptr_q];
  assign fill_count        = cnt_q;
  assign wreq_addr         = addr_q;
  assign wreq_len          = len_q;
  assign last_beat         = (beats_q == LW'(1));
  assign write_buffer_wait = flush_q | (state_q != IDLE) | (cnt_q != '0);

  // Storage carries no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      addr_q   <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    flush_d     = flush_q;
    wreq_valid  = 1'b0;
    wdata_valid = 1'b0;
    wdata_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q >= CW'(BURST_LEN)) begin
          len_d   = LW'(BURST_LEN);
          state_d = REQ;
        end else if (flush_q && cnt_q != '0) begin
          len_d   = LW'(cnt_q);
          state_d = REQ;
        end else if (flush_q) begin
          flush_d = 1'b0;
        end
      end
      REQ: begin
        wreq_valid = 1'b1;
        if (wreq_ready) begin
          beats_d = len_q;
          state_d = DATA;
        end
      end
      DATA: begin
        wdata_valid = 1'b1;
        wdata_last  = last_beat;
        if (wdata_ready) begin
          beats_d = beats_q - LW'(1);
          if (last_beat) begin
            addr_d  = addr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(WORD_BYTE);
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: if (wmst_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // A new end_conv must not be lost to the empty-buffer clear above.
    if (end_conv) flush_d = 1'b1;
    if (op_start) begin
      addr_d  = base_addr;
      flush_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_wr_buf.sv
// Randomized bench for acc_wr_buf: a queue-based model tracks words, bursts and addresses.
module tb_acc_wr_buf;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 5;
  localparam int CW = 7;

  logic          clk = 1'b0, rst = 1'b1;
  logic          op_start = 1'b0, end_conv = 1'b0, in_valid = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          wreq_ready = 1'b0, wdata_ready = 1'b0, wmst_done = 1'b0;
  logic          in_ready, wreq_valid, wdata_valid, wdata_last, write_buffer_wait;
  logic [AW-1:0] wreq_addr;
  logic [LW-1:0] wreq_len;
  logic [DW-1:0] wdata;
  logic [CW-1:0] fill_count;

  acc_wr_buf dut (
    .clk(clk), .rst(rst), .op_start(op_start), .base_addr(base_addr), .end_conv(end_conv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready), .wreq_addr(wreq_addr), .wreq_len(wreq_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wdata_last(wdata_last),
    .wmst_done(wmst_done), .write_buffer_wait(write_buffer_wait), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: word queue, burst log, expected next address
  logic [DW-1:0] mq[$];
  int            log_len[$];
  logic [AW-1:0] log_addr[$];
  int            pop_cycles[$];
  logic [AW-1:0] exp_addr = '0;
  int cur_len = 0, beat_n = 0, n_beats = 0, n_bursts = 0, n_done = 0, ncyc = 0, last_push = 0;

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      mq.delete();
      beat_n = 0;
    end else begin
      chk("fill_count", fill_count, mq.size());
      if (op_start) exp_addr = base_addr;
      if (wmst_done) n_done++;
      if (wreq_valid && wreq_ready) begin
        chk("wreq_addr", wreq_addr, exp_addr);
        log_len.push_back(int'(wreq_len));
        log_addr.push_back(wreq_addr);
        cur_len = int'(wreq_len);
        beat_n  = 0;
      end
      if (wdata_valid && wdata_ready) begin
        beat_n++;
        n_beats++;
        pop_cycles.push_back(ncyc);
        if (mq.size() == 0) chk("underflow", 1, 0);
        else chk("wdata", wdata, mq.pop_front());
        chk("wdata_last", wdata_last, beat_n == cur_len);
        if (beat_n == cur_len) begin
          exp_addr = exp_addr + AW'(cur_len * 64);
          n_bursts++;
        end
      end
      if (in_valid && in_ready) begin
        mq.push_back(in_data);
        last_push = ncyc;
      end
    end
  end

  // Write-master responder: ready patterns and a delayed wmst_done per completed burst
  int wd_mode = 0, wr_mode = 0, served = 0, dly = 0;
  always @(posedge clk) begin
    #1;
    wmst_done = 1'b0;
    if (wr_mode == 0) wreq_ready = 1'b1;
    else wreq_ready = 1'($urandom_range(0, 1));
    case (wd_mode)
      0: wdata_ready = 1'b1;
      1: wdata_ready = 1'b0;
      2: wdata_ready = ~wdata_ready;
      default: wdata_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst) begin
      served = n_bursts;
      dly    = 0;
    end else if (n_bursts > served) begin
      if (dly == 0) dly = $urandom_range(1, 4);
      else begin
        dly--;
        if (dly == 0) begin
          wmst_done = 1'b1;
          served++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic start(input logic [AW-1:0] a);
    base_addr = a;
    op_start  = 1'b1;
    tick();
    op_start  = 1'b0;
  endtask

  task automatic pulse_end();
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit ok;
    int g = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      tick();
      g++;
    end while (!ok && g < 3000);
    if (!ok) chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic push_n(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      push_word(rnd_word());
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (write_buffer_wait && g < 5000);
    chk(tag, write_buffer_wait, 0);
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l0, b0, d0, p0, sum;
    logic [DW-1:0] w;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wreq_valid", wreq_valid, 0);
    chk("rst_wdata_valid", wdata_valid, 0);
    chk("rst_wdata_last", wdata_last, 0);
    chk("rst_wbw", write_buffer_wait, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fill", fill_count, 0);
    tick();

    // single full burst
    l0 = log_len.size(); b0 = n_beats;
    start(64'h1000);
    push_n(16, 0);
    wait_idle("t1_idle");
    chk("t1_nreq", log_len.size() - l0, 1);
    if (log_len.size() > l0) begin
      chk("t1_len", log_len[l0], 16);
      chk("t1_addr", log_addr[l0], 64'h1000);
    end
    chk("t1_beats", n_beats - b0, 16);

    // 40 words + flush -> 16/16/8
    l0 = log_len.size(); d0 = n_done;
    start(64'h1000);
    push_n(40, 0);
    pulse_end();
    wait_idle("t2_idle");
    chk("t2_done_cnt", n_done - d0, 3);
    chk("t2_nreq", log_len.size() - l0, 3);
    if (log_len.size() >= l0 + 3) begin
      chk("t2_len0", log_len[l0], 16);   chk("t2_addr0", log_addr[l0], 64'h1000);
      chk("t2_len1", log_len[l0+1], 16); chk("t2_addr1", log_addr[l0+1], 64'h1400);
      chk("t2_len2", log_len[l0+2], 8);  chk("t2_addr2", log_addr[l0+2], 64'h1800);
    end

    // fill to DEPTH with the sink stalled
    wd_mode = 1;
    l0 = log_len.size(); p0 = pop_cycles.size();
    start(64'h2000);
    push_n(64, 0);
    @(negedge clk);
    chk("t3_full_fill", fill_count, 64);
    chk("t3_full_ready", in_ready, 0);
    tick();
    w = rnd_word();
    in_valid = 1'b1;
    in_data  = w;
    repeat (4) begin
      @(negedge clk);
      chk("t3_stall_ready", in_ready, 0);
      tick();
    end
    wd_mode = 0;
    push_word(w);
    if (pop_cycles.size() > p0) chk("t3_accept_cycle", last_push, pop_cycles[p0] + 1);
    else chk("t3_no_pop", 0, 1);
    pulse_end();
    wait_idle("t3_idle");
    chk("t3_nreq", log_len.size() - l0, 5);
    if (log_len.size() >= l0 + 5) begin
      chk("t3_last_len", log_len[l0+4], 1);
      chk("t3_last_addr", log_addr[l0+4], 64'h3000);
    end

    // end_conv on an empty buffer
    l0 = log_len.size();
    end_conv = 1'b1;
    @(negedge clk);
    chk("t4_wbw_c0", write_buffer_wait, 0);
    tick();
    end_conv = 1'b0;
    @(negedge clk);
    chk("t4_wbw_c1", write_buffer_wait, 1);
    @(negedge clk);
    chk("t4_wbw_c2", write_buffer_wait, 0);
    repeat (5) @(negedge clk);
    chk("t4_wbw_late", write_buffer_wait, 0);
    chk("t4_nreq", log_len.size() - l0, 0);
    tick();

    // toggling sink, gapped producer
    wd_mode = 2; wr_mode = 1;
    l0 = log_len.size(); b0 = n_beats;
    start(64'h3000);
    push_n(50, 1);
    pulse_end();
    wait_idle("t5_idle");
    chk("t5_beats", n_beats - b0, 50);
    chk("t5_model_empty", mq.size(), 0);
    sum = 0;
    for (int i = l0; i < log_len.size(); i++) sum += log_len[i];
    chk("t5_len_sum", sum, 50);

    // fully random rounds
    for (int it = 0; it < 4; it++) begin
      int n;
      wd_mode = 3;
      n  = $urandom_range(1, 90);
      l0 = log_len.size(); b0 = n_beats;
      start({32'($urandom), 32'($urandom)} & ~64'hfff);
      push_n(n, 1);
      pulse_end();
      wait_idle("t6_idle");
      chk("t6_beats", n_beats - b0, n);
      sum = 0;
      for (int i = l0; i < log_len.size(); i++) begin
        sum += log_len[i];
        if (i < log_len.size() - 1) chk("t6_full_len", log_len[i], 16);
      end
      chk("t6_len_sum", sum, n);
    end

    // reset in the middle of a data phase
    wd_mode = 1; wr_mode = 0;
    start(64'h4000);
    push_n(10, 0);
    pulse_end();
    begin
      int g = 0;
      do begin @(negedge clk); g++; end while (!wdata_valid && g < 100);
      chk("t7_in_data", wdata_valid, 1);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t7_wreq_valid", wreq_valid, 0);
    chk("t7_wdata_valid", wdata_valid, 0);
    chk("t7_wdata_last", wdata_last, 0);
    chk("t7_wbw", write_buffer_wait, 0);
    chk("t7_in_ready", in_ready, 1);
    chk("t7_fill", fill_count, 0);
    tick();
    rst = 1'b0;
    wd_mode = 0;
    tick();
    l0 = log_len.size();
    start(64'h5000);
    push_n(20, 0);
    pulse_end();
    wait_idle("t7_idle");
    chk("t7_nreq", log_len.size() - l0, 2);
    if (log_len.size() >= l0 + 2) begin
      chk("t7_len0", log_len[l0], 16);  chk("t7_addr0", log_addr[l0], 64'h5000);
      chk("t7_len1", log_len[l0+1], 4); chk("t7_addr1", log_addr[l0+1], 64'h5400);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_wr_buf.md
# acc_wr_buf

Output write buffer between the convolution engine's result stream and the AXI write master. Accepts result words, groups them into bursts of up to BURST_LEN words, and issues address/length requests with the matching data beats to the write master. Reports `write_buffer_wait` to the engine controller so that `ap_done` is raised only after every result word has been written and acknowledged by `wmst_done`.

## Interface
- DATA_WIDTH, 512, result word width in bits.
- WORD_BYTE, DATA_WIDTH/8, bytes per word; used as the address stride.
- DEPTH, 64, FIFO depth in words; power of two, must be ≥ BURST_LEN.
- BURST_LEN, 16, maximum words per write burst; power of two.
- ADDR_WIDTH, 64, byte address width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_start  in  1  one-cycle pulse from the controller; latches base_addr.
- base_addr  in  ADDR_WIDTH  output region start address; WORD_BYTE-aligned.
- end_conv  in  1  one-cycle pulse: engine produced its last word; starts the flush.
- in_valid / in_ready  in / out  1  result-word handshake.
- in_data  in  DATA_WIDTH  result word.
- wreq_valid / wreq_ready  out / in  1  burst request handshake.
- wreq_addr  out  ADDR_WIDTH  burst start byte address.
- wreq_len  out  $clog2(BURST_LEN)+1  beats in the burst, range 1..BURST_LEN.
- wdata_valid / wdata_ready  out / in  1  data beat handshake.
- wdata  out  DATA_WIDTH  beat data (FIFO head).
- wdata_last  out  1  high on the final beat of a burst.
- wmst_done  in  1  one-cycle pulse: the write master completed the current burst (B response).
- write_buffer_wait  out  1  high while any data is buffered, in flight or flushing.
- fill_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- The FIFO has DEPTH entries, with wrapping read and write pointers and an occupancy counter. Head read is combinational: wdata = mem[rd_ptr].
- Push when in_valid && in_ready. Pop when wdata_valid && wdata_ready. A push and a pop in the same cycle leave the count unchanged.
- in_ready = (fill_count != DEPTH). A push attempted while full is not accepted, and the data is held by the producer.
- On op_start: next_addr <= base_addr and flush_pend <= 0. op_start arrives only while write_buffer_wait = 0.
- On end_conv: flush_pend <= 1. The engine's last in_valid handshake occurs no later than the end_conv cycle.
- FSM states are IDLE, REQ, DATA and WAIT_DONE.
- IDLE:
  - If fill_count ≥ BURST_LEN, latch len = BURST_LEN and go to REQ.
  - Else if flush_pend && fill_count != 0, latch len = fill_count and go to REQ.
  - Else if flush_pend && fill_count == 0, clear flush_pend and stay in IDLE.
- REQ: wreq_valid = 1, with wreq_addr = next_addr and wreq_len = len held stable. On wreq_ready, set beats_left = len and go to DATA.
- DATA: wdata_valid = 1. wdata_last = (beats_left == 1). Each accepted beat decrements beats_left. The last accepted beat sets next_addr <= next_addr + len*WORD_BYTE and moves to WAIT_DONE.
- WAIT_DONE: on wmst_done, go to IDLE. Only one burst is outstanding at any time.
- wmst_done outside WAIT_DONE is ignored.
- write_buffer_wait = flush_pend | (state != IDLE) | (fill_count != 0). This is a registered-source combinational OR.
- Address arithmetic is modulo 2^ADDR_WIDTH with no 4 KB boundary split. The software allocates buffers so that no burst crosses 4 KB.

## Timing
- Reset values:
  - state = IDLE, fill_count = 0, pointers = 0, flush_pend = 0, next_addr = 0.
  - Outputs wreq_valid, wdata_valid, wdata_last and write_buffer_wait are 0.
  - in_ready = 1.
- Reset asserted mid-burst discards all buffered data and outstanding requests immediately. There is no wait for wmst_done.
- Request latency: the FSM leaves IDLE on the edge where the threshold is met, and wreq_valid is high in the following cycle.
- DATA may run one beat per cycle when wdata_ready is held high.
- The data phase of a burst may continue while new words are pushed; len is fixed at REQ entry.
- end_conv with an empty, idle buffer: write_buffer_wait is high for exactly one cycle, the cycle after end_conv, and low thereafter.
- end_conv while a burst is in progress: flush_pend waits. Remaining words are sent in further bursts. write_buffer_wait falls the cycle after flush_pend clears in IDLE with fill_count == 0.
- A push coincident with end_conv is counted before the flush decision in IDLE.

## Test plan
- Reset, then 16 words pushed back-to-back with wreq_ready, wdata_ready and wmst_done responsive, base_addr 0x1000 → one request with addr 0x1000 and len 16. 16 beats with wdata_last on beat 16, data equal to the input in order.
- 40 words, then end_conv → three bursts: len 16 @0x1000, len 16 @0x1400, len 8 @0x1800. write_buffer_wait falls only after the third wmst_done.
- wdata_ready held low, 64 words pushed → in_ready low at fill_count 64 and the 65th word stalls. It is accepted in the cycle after the first pop.
- end_conv with an empty buffer → write_buffer_wait high for one cycle, no request issued.
- wdata_ready toggling every cycle with concurrent pushes → fill_count stays consistent and there is no data loss or reorder. wdata_last appears exactly once per burst.
- rst asserted in DATA with 10 words buffered → all outputs at reset values the next cycle. A new op_start/burst sequence completes correctly.
